// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the iterative multiply/divide unit.
// Op encodings, MDU state enum and the iteration count live here.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 1);

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the execute-stage control and alu_mdu.
// The master drives operands and commands; the slave returns results, flags and HI/LO.
interface alu_mdu_if;

    logic [3:0]  AluOp;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Out;
    logic        Zero;
    logic        Negative;
    logic        Overflow;
    logic        MdStart;
    logic [1:0]  MdOp;
    logic [1:0]  HiLoWe;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output AluOp, Signed, A, B, MdStart, MdOp, HiLoWe,
        input  Out, Zero, Negative, Overflow, Busy, Hi, Lo
    );

    modport slave (
        input  AluOp, Signed, A, B, MdStart, MdOp, HiLoWe,
        output Out, Zero, Negative, Overflow, Busy, Hi, Lo
    );

endinterface

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes,
// followed by one sign-fixup cycle that writes HI/LO. Divide support needs ALU_MDU_DIV_EN.
module mdu_core
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  hilo_we,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state, state_nxt;
    logic [4:0]  cnt;
    logic        accept;
    logic        op_signed;
    logic        sign_a_in, sign_b_in;
    logic [31:0] mag_a_in, mag_b_in;

    logic        sign_a, sign_b;
    logic [31:0] mag_b;
    logic [63:0] acc, acc_nxt;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [31:0] fix_hi, fix_lo;

`ifdef ALU_MDU_DIV_EN
    logic        div_q;
    logic        b_zero;
    logic [31:0] a_raw;
    logic [32:0] rem_sh, trial;

    assign accept = (state == MD_IDLE) && start;
`else
    assign accept = (state == MD_IDLE) && start && ((op == MD_MULT) || (op == MD_MULTU));
`endif

    assign busy      = (state != MD_IDLE);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign sign_a_in = op_signed & a[31];
    assign sign_b_in = op_signed & b[31];
    assign mag_a_in  = sign_a_in ? -a : a;
    assign mag_b_in  = sign_b_in ? -b : b;

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == LAST_ITER) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration step: acc holds {partial high, multiplier} or {remainder, quotient/dividend}.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + {1'b0, mag_b};
        acc_nxt = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
`ifdef ALU_MDU_DIV_EN
        rem_sh = {acc[63:32], acc[31]};
        trial  = rem_sh - {1'b0, mag_b};
        if (div_q) begin
            acc_nxt = trial[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                : {trial[31:0],  acc[30:0], 1'b1};
        end
`endif
    end

    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        fix_hi = prod[63:32];
        fix_lo = prod[31:0];
`ifdef ALU_MDU_DIV_EN
        if (div_q) begin
            if (b_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = sign_a            ? -acc[63:32] : acc[63:32];
                fix_lo = (sign_a ^ sign_b) ? -acc[31:0]  : acc[31:0];
            end
        end
`endif
    end

    // HI/LO only change on a completed FIX or an MTHI/MTLO that does not collide with a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    cnt <= '0;
                    if (!accept) begin
                        if (hilo_we[1]) hi <= a;
                        if (hilo_we[0]) lo <= a;
                    end
                end
                MD_RUN:  cnt <= cnt + 5'd1;
                MD_FIX: begin
                    cnt <= '0;
                    hi  <= fix_hi;
                    lo  <= fix_lo;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: operand/accumulator registers carry no reset; they are always loaded on accept before use.
        if (accept) begin
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            mag_b  <= mag_b_in;
            acc    <= {32'h0, mag_a_in};
`ifdef ALU_MDU_DIV_EN
            div_q  <= (op == MD_DIV) || (op == MD_DIVU);
            b_zero <= (b == 32'h0);
            a_raw  <= a;
`endif
        end else if (state == MD_RUN) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic: combinational ALU with compare flags plus the iterative MDU.
// Define ALU_MDU_DIV_EN to include the divider; otherwise DIV/DIVU starts are ignored.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input logic        clk,
    input logic        reset,
    alu_mdu_if.slave   bus
);

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sum;
    logic             ovf_add, ovf_sub;

    assign diff = {1'b0, bus.A} - {1'b0, bus.B};
    assign sum  = bus.A + bus.B;

    assign ovf_add = ~(bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (bus.A[WIDTH-1] ^ sum[WIDTH-1]);
    assign ovf_sub =  (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (bus.A[WIDTH-1] ^ diff[WIDTH-1]);

    // Flags come from A-B regardless of AluOp; the compare stage consumes them directly.
    assign bus.Zero     = (bus.A == bus.B);
    assign bus.Negative = bus.Signed ? (diff[WIDTH-1] ^ ovf_sub) : diff[WIDTH];

    always_comb begin
        bus.Out      = '0;
        bus.Overflow = 1'b0;
        case (alu_op_e'(bus.AluOp))
            ALU_ADD: begin
                bus.Out      = sum;
                bus.Overflow = bus.Signed & ovf_add;
            end
            ALU_SUB: begin
                bus.Out      = diff[WIDTH-1:0];
                bus.Overflow = bus.Signed & ovf_sub;
            end
            ALU_AND: bus.Out = bus.A & bus.B;
            ALU_OR:  bus.Out = bus.A | bus.B;
            ALU_XOR: bus.Out = bus.A ^ bus.B;
            ALU_NOR: bus.Out = ~(bus.A | bus.B);
            ALU_SLL: bus.Out = bus.B << bus.A[4:0];
            ALU_SRL: bus.Out = bus.B >> bus.A[4:0];
            ALU_SRA: bus.Out = $unsigned($signed(bus.B) >>> bus.A[4:0]);
            ALU_LUI: bus.Out = {bus.B[15:0], 16'h0};
            default: bus.Out = '0;
        endcase
    end

    mdu_core u_mdu (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.MdStart),
        .op      (bus.MdOp),
        .a       (bus.A),
        .b       (bus.B),
        .hilo_we (bus.HiLoWe),
        .busy    (bus.Busy),
        .hi      (bus.Hi),
        .lo      (bus.Lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu: ALU flags/results, MDU timing, results, reset abort
// and the ignore rules for MdStart/HiLoWe while busy.
module tb_alu_mdu;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_mdu_if bus ();

    alu_mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an MDU op, scramble operands, wait for Busy to drop and check duration and HI/LO.
    task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.MdOp    = op;
        bus.A       = a;
        bus.B       = b;
        bus.MdStart = 1'b1;
        tick();
        bus.MdStart = 1'b0;
        bus.A       = 32'hDEAD_BEEF;
        bus.B       = 32'h0000_0001;
        n = 0;
        while (bus.Busy && n < 40) begin
            tick();
            n++;
        end
        check({tag, " busy cycles"}, 32'(n), 32'd33);
        check({tag, " hi"}, bus.Hi, exp_hi);
        check({tag, " lo"}, bus.Lo, exp_lo);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        bus.AluOp   = 4'd0;
        bus.Signed  = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.MdStart = 1'b0;
        bus.MdOp    = 2'b00;
        bus.HiLoWe  = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset busy", 32'(bus.Busy), 32'd0);
        check("reset hi", bus.Hi, 32'h0);
        check("reset lo", bus.Lo, 32'h0);

        // ALU flags and results
        bus.A = 32'hFFFF_FFFF; bus.B = 32'h1; bus.Signed = 1'b1; #1;
        check("neg signed", 32'(bus.Negative), 32'd1);
        check("zero ne", 32'(bus.Zero), 32'd0);
        bus.Signed = 1'b0; #1;
        check("neg unsigned", 32'(bus.Negative), 32'd0);
        bus.A = 32'd5; bus.B = 32'd5; #1;
        check("zero eq", 32'(bus.Zero), 32'd1);
        check("neg eq", 32'(bus.Negative), 32'd0);
        bus.A = 32'd3; bus.B = 32'd7; #1;
        check("neg borrow", 32'(bus.Negative), 32'd1);
        bus.AluOp = 4'd0; bus.A = 32'h7FFF_FFFF; bus.B = 32'h1; bus.Signed = 1'b1; #1;
        check("add ovf out", bus.Out, 32'h8000_0000);
        check("add ovf", 32'(bus.Overflow), 32'd1);
        bus.Signed = 1'b0; #1;
        check("add ovf unsigned", 32'(bus.Overflow), 32'd0);
        bus.AluOp = 4'd1; bus.A = 32'h8000_0000; bus.B = 32'h1; bus.Signed = 1'b1; #1;
        check("sub out", bus.Out, 32'h7FFF_FFFF);
        check("sub ovf", 32'(bus.Overflow), 32'd1);
        bus.AluOp = 4'd5; bus.A = 32'h0F0F_0000; bus.B = 32'h0000_00F0; #1;
        check("nor out", bus.Out, 32'hF0F0_FF0F);
        check("nor ovf", 32'(bus.Overflow), 32'd0);
        bus.AluOp = 4'd6; bus.A = 32'd4; bus.B = 32'h8000_0001; #1;
        check("sll out", bus.Out, 32'h0000_0010);
        bus.AluOp = 4'd7; #1;
        check("srl out", bus.Out, 32'h0800_0000);
        bus.AluOp = 4'd8; #1;
        check("sra out", bus.Out, 32'hF800_0000);
        bus.AluOp = 4'd9; bus.B = 32'hABCD_1234; #1;
        check("lui out", bus.Out, 32'h1234_0000);
        bus.AluOp = 4'd12; #1;
        check("undef op out", bus.Out, 32'h0);
        bus.Signed = 1'b0;

        // MDU multiply
        run_md("mult", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

`ifdef ALU_MDU_DIV_EN
        run_md("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu by zero", 2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        run_md("div min by -1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
`else
        bus.MdOp = 2'b10; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2; bus.MdStart = 1'b1;
        tick();
        bus.MdStart = 1'b0;
        check("div disabled busy", 32'(bus.Busy), 32'd0);
        tick();
        check("div disabled hi", bus.Hi, 32'hFFFF_FFFE);
        check("div disabled lo", bus.Lo, 32'h0000_0001);
`endif

        // MTHI/MTLO
        bus.A = 32'h0000_1234; bus.HiLoWe = 2'b11;
        tick();
        bus.HiLoWe = 2'b00;
        check("mthi", bus.Hi, 32'h0000_1234);
        check("mtlo", bus.Lo, 32'h0000_1234);
        bus.A = 32'h0000_0055; bus.HiLoWe = 2'b01;
        tick();
        bus.HiLoWe = 2'b00;
        check("mtlo only hi", bus.Hi, 32'h0000_1234);
        check("mtlo only lo", bus.Lo, 32'h0000_0055);

        // Reset mid-operation aborts without writing HI/LO
        bus.MdOp = 2'b01; bus.A = 32'd5; bus.B = 32'd6; bus.MdStart = 1'b1;
        tick();
        bus.MdStart = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre-reset busy", 32'(bus.Busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(bus.Busy), 32'd0);
        check("abort hi", bus.Hi, 32'h0);
        check("abort lo", bus.Lo, 32'h0);

        // MdStart and HiLoWe pulsed while busy are ignored
        bus.MdOp = 2'b01; bus.A = 32'd6; bus.B = 32'd7; bus.MdStart = 1'b1;
        tick();
        bus.MdStart = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.MdOp = 2'b00; bus.A = 32'd3; bus.B = 32'd3; bus.MdStart = 1'b1; bus.HiLoWe = 2'b11;
        tick();
        bus.MdStart = 1'b0; bus.HiLoWe = 2'b00;
        check("busy mthi ignored", bus.Hi, 32'h0);
        check("busy mtlo ignored", bus.Lo, 32'h0);
        n = 0;
        while (bus.Busy && n < 40) begin
            tick();
            n++;
        end
        check("ignore busy remaining", 32'(n), 32'd28);
        check("ignore hi", bus.Hi, 32'h0);
        check("ignore lo", bus.Lo, 32'd42);

        // HiLoWe together with an accepted start is dropped
        bus.MdOp = 2'b01; bus.A = 32'd2; bus.B = 32'd3; bus.MdStart = 1'b1; bus.HiLoWe = 2'b11;
        tick();
        bus.MdStart = 1'b0; bus.HiLoWe = 2'b00;
        check("collide busy", 32'(bus.Busy), 32'd1);
        check("collide hi kept", bus.Hi, 32'h0);
        check("collide lo kept", bus.Lo, 32'd42);
        n = 0;
        while (bus.Busy && n < 40) begin
            tick();
            n++;
        end
        check("collide hi", bus.Hi, 32'h0);
        check("collide lo", bus.Lo, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
